// File: rtl/cmndf_threshold_module.sv
// YIN cumulative-mean-normalised difference stage with absolute-threshold lag search.
// state  | meaning: IDLE wait start | ACCEPT take d(tau) | DIVIDE quotient bits | EMIT output d', search | FINISH done pulse
module cmndf_threshold_module #(
  parameter int DIFF_WIDTH = 32,
  parameter int MAX_TAU    = 64,
  parameter int TAU_BITS   = 6,
  parameter int FRAC_BITS  = 12,
  parameter int MIN_TAU    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [TAU_BITS+FRAC_BITS-1:0] threshold,
  input  logic                          diff_valid,
  input  logic [DIFF_WIDTH-1:0]         diff_data,
  output logic                          diff_ready,
  output logic                          cmndf_valid,
  output logic [TAU_BITS+FRAC_BITS-1:0] cmndf_value,
  output logic [TAU_BITS-1:0]           cmndf_tau,
  output logic                          done,
  output logic                          found,
  output logic [TAU_BITS-1:0]           tau_out,
  output logic [TAU_BITS+FRAC_BITS-1:0] min_value
);
  localparam int VW = TAU_BITS + FRAC_BITS;
  localparam int SW = DIFF_WIDTH + TAU_BITS;
  localparam int NW = SW + FRAC_BITS;
  localparam int CW = $clog2(NW + 1);
  localparam logic [VW-1:0] ONE = VW'(1) << FRAC_BITS;

  typedef enum logic [2:0] {IDLE, ACCEPT, DIVIDE, EMIT, FINISH} state_t;
  typedef enum logic [1:0] {SEEK, DESCEND, LOCKED} phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [TAU_BITS-1:0] tau_q, tau_d, tau_out_q, tau_out_d;
  logic [SW-1:0]       sum_q, sum_d, dvsr_q, dvsr_d, rem_q, rem_d;
  logic [NW-1:0]       num_q, num_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [VW-1:0]       thr_q, thr_d, val_q, val_d, min_q, min_d;
  logic                found_q, found_d;

  logic [SW:0]   rem_shift;
  logic [SW-1:0] rem_sub, sum_new, prod;
  logic          rem_ge;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tau_d     = tau_q;
    tau_out_d = tau_out_q;
    sum_d     = sum_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    val_d     = val_q;
    min_d     = min_q;
    found_d   = found_q;

    // numerator bits shift out the top while quotient bits fill in at the bottom
    rem_shift = {rem_q, num_q[NW-1]};
    rem_ge    = rem_shift >= {1'b0, dvsr_q};
    rem_sub   = rem_shift[SW-1:0] - dvsr_q;
    sum_new   = sum_q + SW'(diff_data);
    prod      = SW'(diff_data) * SW'(tau_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCEPT;
          tau_d     = '0;
          sum_d     = '0;
          found_d   = 1'b0;
          tau_out_d = '0;
          min_d     = '0;
          thr_d     = threshold;
          phase_d   = SEEK;
        end
      end
      ACCEPT: begin
        if (diff_valid) begin
          if (tau_q == '0) begin
            val_d   = ONE;
            state_d = EMIT;
          end else begin
            sum_d = sum_new;
            if (sum_new == '0) begin
              val_d   = ONE;
              state_d = EMIT;
            end else begin
              num_d   = {prod, {FRAC_BITS{1'b0}}};
              rem_d   = '0;
              dvsr_d  = sum_new;
              cnt_d   = CW'(NW - 1);
              state_d = DIVIDE;
            end
          end
        end
      end
      DIVIDE: begin
        num_d = {num_q[NW-2:0], rem_ge};
        rem_d = rem_ge ? rem_sub : rem_shift[SW-1:0];
        if (cnt_q == '0) begin
          val_d   = num_d[VW-1:0];
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EMIT: begin
        if (tau_q >= TAU_BITS'(MIN_TAU)) begin
          case (phase_q)
            SEEK: begin
              if (val_q < thr_q) begin
                found_d   = 1'b1;
                tau_out_d = tau_q;
                min_d     = val_q;
                phase_d   = DESCEND;
              end else if (tau_q == TAU_BITS'(MIN_TAU) || val_q < min_q) begin
                tau_out_d = tau_q;
                min_d     = val_q;
              end
            end
            DESCEND: begin
              if (val_q < min_q) begin
                tau_out_d = tau_q;
                min_d     = val_q;
              end else begin
                phase_d = LOCKED;
              end
            end
            default: ;
          endcase
        end
        if (tau_q == TAU_BITS'(MAX_TAU - 1)) begin
          state_d = FINISH;
        end else begin
          tau_d   = tau_q + 1'b1;
          state_d = ACCEPT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= SEEK;
      tau_q     <= '0;
      tau_out_q <= '0;
      sum_q     <= '0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      thr_q     <= '0;
      val_q     <= '0;
      min_q     <= '0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tau_q     <= tau_d;
      tau_out_q <= tau_out_d;
      sum_q     <= sum_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      thr_q     <= thr_d;
      val_q     <= val_d;
      min_q     <= min_d;
      found_q   <= found_d;
    end
  end

  assign diff_ready  = (state_q == ACCEPT);
  assign cmndf_valid = (state_q == EMIT);
  assign cmndf_value = val_q;
  assign cmndf_tau   = tau_q;
  assign done        = (state_q == FINISH);
  assign found       = found_q;
  assign tau_out     = tau_out_q;
  assign min_value   = min_q;
endmodule

// File: tb/tb_cmndf_threshold_module.sv
// Directed bench for cmndf_threshold_module: frame-level d'/search model plus per-cycle output compare.
module tb_cmndf_threshold_module;
  localparam int DW = 32, MT = 64, TB = 6, FB = 12, MN = 2;
  localparam int VW = TB + FB;
  localparam int LAT_DIV = DW + TB + FB + 1;

  logic          clk = 1'b0;
  logic          reset, start, diff_valid;
  logic [VW-1:0] threshold;
  logic [DW-1:0] diff_data;
  logic          diff_ready, cmndf_valid, done, found;
  logic [VW-1:0] cmndf_value, min_value;
  logic [TB-1:0] cmndf_tau, tau_out;

  always #5 clk = ~clk;

  cmndf_threshold_module #(.DIFF_WIDTH(DW), .MAX_TAU(MT), .TAU_BITS(TB), .FRAC_BITS(FB), .MIN_TAU(MN)) dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .diff_valid(diff_valid), .diff_data(diff_data), .diff_ready(diff_ready),
    .cmndf_valid(cmndf_valid), .cmndf_value(cmndf_value), .cmndf_tau(cmndf_tau),
    .done(done), .found(found), .tau_out(tau_out), .min_value(min_value));

  int errors = 0, checks = 0, cyc = 0;
  longint unsigned dv[MT];
  longint unsigned ev[MT];
  bit  enodiv[MT];
  bit  ef;
  int  et;
  longint unsigned em;
  int  exp_idx = 0, frames_done = 0, hs_cyc = 0;
  bit  expect_done = 1'b0, pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // d' straight from its definition, then the threshold search on the finished array
  function automatic void model(input longint unsigned thr);
    longint unsigned s = 0;
    int first = -1, c;
    for (int t = 0; t < MT; t++) begin
      if (t == 0) begin ev[t] = 4096; enodiv[t] = 1; end
      else begin
        s += dv[t];
        if (s == 0) begin ev[t] = 4096; enodiv[t] = 1; end
        else begin ev[t] = (dv[t] * longint'(t) * 4096) / s; enodiv[t] = 0; end
      end
    end
    for (int t = MN; t < MT; t++)
      if (first < 0 && ev[t] < thr) first = t;
    if (first >= 0) begin
      c = first;
      while (c + 1 < MT && ev[c+1] < ev[c]) c++;
      ef = 1; et = c; em = ev[c];
    end else begin
      ef = 0; et = MN; em = ev[MN];
      for (int t = MN + 1; t < MT; t++)
        if (ev[t] < em) begin et = t; em = ev[t]; end
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (pending) chk("ready_low_while_busy", diff_ready, 0);
      if (cmndf_valid) begin
        chk("cmndf_valid_expected", pending && exp_idx < MT, 1);
        if (exp_idx < MT) begin
          chk("cmndf_tau", cmndf_tau, exp_idx);
          chk("cmndf_value", cmndf_value, ev[exp_idx]);
          chk("cmndf_latency", cyc - hs_cyc, enodiv[exp_idx] ? 1 : LAT_DIV);
        end
        exp_idx++;
        pending = 1'b0;
      end
      if (done) begin
        chk("done_expected", expect_done, 1);
        chk("done_tau_count", exp_idx, MT);
        chk("found", found, ef);
        chk("tau_out", tau_out, et);
        chk("min_value", min_value, em);
        expect_done = 1'b0;
        frames_done++;
      end
      if (diff_valid && diff_ready) begin
        hs_cyc  = cyc;
        pending = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!diff_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("ready_wait", diff_ready, 1);
  endtask

  task automatic send(input longint unsigned d);
    diff_data  = DW'(d);
    diff_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    diff_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0 plain, 1 ignored starts plus a long stall, 2 reset while tau=20 divides
  task automatic run_frame(input longint unsigned thr, input int mode);
    int fd0, n;
    model(thr);
    exp_idx = 0; expect_done = 1'b1; fd0 = frames_done;
    threshold = VW'(thr);
    pulse_start();
    threshold = '0;
    for (int t = 0; t < MT; t++) begin
      if (mode == 1 && t == 30) begin wait_ready(); pulse_start(); end
      send(dv[t]);
      if (mode == 1 && t == 15) pulse_start();
      if (mode == 1 && t == 20) begin
        repeat (LAT_DIV + 30) @(posedge clk);
        #1;
        chk("stall_ready", diff_ready, 1);
      end
      if (mode == 2 && t == 20) begin
        repeat (5) @(posedge clk);
        #1;
        expect_done = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_outputs", {diff_ready, cmndf_valid, cmndf_value, cmndf_tau, done, found, tau_out, min_value}, 0);
        repeat (100) @(posedge clk);
        #1;
        chk("no_done_after_reset", frames_done - fd0, 0);
        return;
      end
    end
    n = 0;
    while (frames_done == fd0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("frame_done", frames_done - fd0, 1);
  endtask

  task automatic load_t2();
    for (int t = 0; t < MT; t++) dv[t] = 1000;
    dv[10] = 10; dv[11] = 5; dv[12] = 50;
  endtask

  task automatic chk_t2_result(input string tag);
    chk({tag, "_found"}, found, 1);
    chk({tag, "_tau_out"}, tau_out, 11);
    chk({tag, "_min"}, min_value, 24);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; diff_valid = 1'b0; diff_data = '0; threshold = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("init_outputs", {diff_ready, cmndf_valid, cmndf_value, cmndf_tau, done, found, tau_out, min_value}, 0);

    for (int t = 0; t < MT; t++) dv[t] = (t == 0) ? 0 : 100;
    run_frame(410, 0);
    chk("t1_model_val", ev[37], 4096);
    chk("t1_found", found, 0);
    chk("t1_tau_out", tau_out, 2);
    chk("t1_min", min_value, 4096);

    load_t2();
    model(410);
    chk("t2_model_v10", ev[10], 45);
    chk("t2_model_v11", ev[11], 24);
    chk("t2_model_v12", ev[12], 271);
    chk("t2_model_tau", et, 11);
    run_frame(410, 0);
    chk_t2_result("t2");

    for (int t = 0; t < MT; t++) dv[t] = 0;
    run_frame(410, 0);
    chk("t3_found", found, 0);
    chk("t3_tau_out", tau_out, 2);
    chk("t3_min", min_value, 4096);

    dv[0] = 3; dv[1] = 7;
    for (int t = 2; t < MT; t++) dv[t] = $urandom_range(0, 5000);
    run_frame($urandom_range(100, 3000), 0);
    chk("t4_held_tau", tau_out, et);

    for (int t = 0; t < MT; t++) dv[t] = $urandom();
    run_frame(2000, 0);

    load_t2();
    run_frame(410, 2);
    run_frame(410, 0);
    chk_t2_result("t5");

    run_frame(410, 1);
    chk_t2_result("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmndf_threshold_module.md
Name: cmndf_threshold_module

Overview:
Parametrised successor to the current CMNDF stage of the YIN pitch path. It consumes a streamed difference function d(tau), tau = 0..MAX_TAU-1, over a valid/ready handshake. For each tau it computes the fixed-point cumulative-mean-normalised difference d'(tau) with an internal sequential divider and emits it. It then runs the YIN absolute-threshold search and reports the pitch lag tau_out. It sits between the diff engines and the period/frequency conversion stage.

Parameters:
DIFF_WIDTH, 32, width of each d(tau) sample (unsigned)
MAX_TAU, 64, number of lags per frame; must be <= 2**TAU_BITS
TAU_BITS, 6, width of lag indices
FRAC_BITS, 12, fractional bits of d' (1.0 = 1<<FRAC_BITS)
MIN_TAU, 2, first lag considered by the search; must satisfy 1 <= MIN_TAU < MAX_TAU

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
threshold  in  TAU_BITS+FRAC_BITS  absolute threshold on d'; sampled on an accepted start
diff_valid  in  1  d(tau) sample valid
diff_data  in  DIFF_WIDTH  d(tau); samples arrive in tau order, starting at tau=0
diff_ready  out  1  block can accept a sample
cmndf_valid  out  1  one-cycle pulse; d'(cmndf_tau) is on cmndf_value
cmndf_value  out  TAU_BITS+FRAC_BITS  d'(tau), unsigned fixed point
cmndf_tau  out  TAU_BITS  lag of cmndf_value
done  out  1  one-cycle pulse when the frame result is valid
found  out  1  1 if some lag went below threshold; held until next accepted start
tau_out  out  TAU_BITS  selected lag; held until next accepted start
min_value  out  TAU_BITS+FRAC_BITS  d'(tau_out); held until next accepted start

Behaviour:
- Reset:
  - All outputs are 0; FSM goes to IDLE.
  - Running sum, search state and the divider are cleared.
  - Reset mid-frame abandons the frame; no done is produced.
- FSM states: IDLE, ACCEPT, DIVIDE, EMIT, FINISH.
  - IDLE: start moves to ACCEPT with tau=0, S=0. On the same edge found, tau_out and min_value clear and threshold is latched.
  - ACCEPT: diff_ready=1 only in this state. A transfer occurs when diff_valid & diff_ready. With diff_valid low, the block waits indefinitely.
  - On transfer of d(0): d'(0) = 1<<FRAC_BITS; next state is EMIT.
  - On transfer of d(tau), tau>=1: S <= S + d(tau).
    - If the new S == 0, then d' = 1<<FRAC_BITS and next state is EMIT.
    - Otherwise next state is DIVIDE, with numerator = (d(tau)*tau) << FRAC_BITS and divisor = new S.
  - DIVIDE: restoring divider, one bit per cycle. Takes exactly DIV_CYCLES = DIFF_WIDTH+TAU_BITS+FRAC_BITS cycles, then goes to EMIT. The quotient is floored.
  - EMIT: for exactly one cycle, cmndf_valid=1 with cmndf_value and cmndf_tau driven. The search update happens in this cycle. Next state is ACCEPT if tau < MAX_TAU-1, otherwise FINISH.
  - FINISH: drives done=1 for one cycle with final found/tau_out/min_value, then returns to IDLE.
- Latency:
  - tau=0 and S==0 cases: cmndf_valid is 1 cycle after the handshake.
  - Otherwise: cmndf_valid is DIV_CYCLES+1 cycles after the handshake.
  - done is 1 cycle after the last cmndf_valid.
- Widths:
  - S is DIFF_WIDTH+TAU_BITS bits.
  - The numerator is DIFF_WIDTH+TAU_BITS+FRAC_BITS bits.
  - Because S >= d(tau), d'(tau) <= tau < 2**TAU_BITS, so the quotient always fits TAU_BITS+FRAC_BITS bits. No saturation logic is required.
- Search, applied only to lags MIN_TAU..MAX_TAU-1:
  - Phase SEEK: the first lag with d' < threshold (strict) sets found=1, records the candidate and enters phase DESCEND.
  - Phase DESCEND: while the next d' < the candidate value (strict), the candidate moves to that lag. The first d' >= the candidate locks it. Later lags are still computed and emitted but do not alter the result.
  - If no lag is below threshold, found=0 and tau_out is the global minimum over the range. Ties resolve to the lowest lag (strict less-than update).
- start outside IDLE is ignored.
- diff_valid outside ACCEPT is ignored.
- The frame always consumes exactly MAX_TAU samples.

Test Plan:
1. Defaults; d(0)=0, all other d(tau)=100; threshold=410 (0.1) -> every cmndf_value=4096; done with found=0, tau_out=2, min_value=4096.
2. Defaults; d(tau)=1000 except d(10)=10, d(11)=5, d(12)=50; threshold=410 -> cmndf_value at tau 10/11/12 = 45/24/271; found=1, tau_out=11, min_value=24.
3. All d(tau)=0 -> every d'=4096 with no DIVIDE cycles (each cmndf_valid 1 cycle after its handshake); found=0, tau_out=2.
4. Latency: handshake of d(0) -> cmndf_valid 1 cycle later; handshake of d(1)=7 -> cmndf_valid exactly 51 cycles later; diff_ready low throughout.
5. Reset asserted one cycle while tau=20 is dividing -> next cycle all outputs 0 and FSM in IDLE; rerun of test 2 gives an identical result and no spurious done.
6. start pulsed during ACCEPT/DIVIDE, and diff_valid held low 30 cycles mid-frame -> frame unaffected, tau does not advance while stalled, final result matches test 2.
